// File: rtl/sensor_frontend.sv
// -----------------------------------------------------------------------------
// sensor_frontend
//
// Ultrasonic ranging front end. On request it fires a trigger burst on
// trig_out, blanks the echo input for a hold-off period, then waits for the
// transducer echo and measures how long it stays high, in clock cycles.
//
// Ports
//   clk             in   single clock, all logic on the rising edge
//   reset           in   asynchronous, active-low reset
//   start_trigger   in   measurement request (only honoured in IDLE)
//   clear_registers in   synchronous abort/clear, wins over everything else
//   echo_raw        in   asynchronous echo pin from the transducer
//   trig_out        out  trigger pin to the transducer
//   trigger_done    out  one-cycle pulse, first cycle after the burst
//   echo_pulse      out  conditioned echo level (high only in ECHO_HIGH)
//   echo_width      out  [15:0] last measured echo high time in clocks
//   echo_valid      out  one-cycle pulse, echo_width updated
//   timeout         out  one-cycle pulse, no echo or echo too long
//   state_dbg       out  [2:0] current FSM state (IDLE=0 .. ECHO_HIGH=4)
//
// Optional build macro
//   ECHO_GLITCH_FILTER_EN  adds a 3-cycle stability filter after the
//                          synchronizer; echo levels shorter than 3 cycles
//                          are rejected. Undefined: echo_s is the plain
//                          2-flop synchronizer output.
//
// Request/event semantics: start_trigger and clear_registers are levels
// sampled on every rising edge (no ready/acknowledge). trigger_done,
// echo_valid and timeout are single-cycle event strobes with no back
// pressure; echo_width holds its value until the next measurement, a clear
// or reset.
// -----------------------------------------------------------------------------
module sensor_frontend #(
  parameter int          TRIG_CYCLES    = 200,
  parameter int          HOLDOFF_CYCLES = 40,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd60000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_trigger,
  input  logic        clear_registers,
  input  logic        echo_raw,
  output logic        trig_out,
  output logic        trigger_done,
  output logic        echo_pulse,
  output logic [15:0] echo_width,
  output logic        echo_valid,
  output logic        timeout,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    HOLDOFF   = 3'd2,
    WAIT_ECHO = 3'd3,
    ECHO_HIGH = 3'd4
  } state_t;

  // Terminal counts: each timed state runs its counter from 0 up to LAST.
  localparam logic [15:0] TRIG_LAST    = 16'(TRIG_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST    = 16'(HOLDOFF_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 16'd1;

  // ---------------------------------------------------------------------------
  // Echo input conditioning
  // ---------------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic echo_s;

  always_comb begin
    sync1_d = echo_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef ECHO_GLITCH_FILTER_EN
  // The filtered level follows the synchronizer only after it has disagreed
  // for 3 consecutive cycles. Both edges see the same added delay, so the
  // measured width is unchanged for pulses of 3 cycles or more.
  logic       filt_q, filt_d;
  logic [1:0] stab_q, stab_d;

  always_comb begin
    filt_d = filt_q;
    stab_d = 2'd0;
    if (sync2_q != filt_q) begin
      if (stab_q == 2'd2) begin
        filt_d = sync2_q;
      end else begin
        stab_d = stab_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
      stab_q <= 2'd0;
    end else begin
      filt_q <= filt_d;
      stab_q <= stab_d;
    end
  end

  assign echo_s = filt_q;
`else
  assign echo_s = sync2_q;
`endif

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  // armed: a low echo has been seen in WAIT_ECHO, so a high is a true rise.
  logic        armed_q, armed_d;
  logic [15:0] echo_width_q, echo_width_d;
  logic        trig_out_q, trig_out_d;
  logic        trigger_done_q, trigger_done_d;
  logic        echo_pulse_q, echo_pulse_d;
  logic        echo_valid_q, echo_valid_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    armed_d        = 1'b0;
    echo_width_d   = echo_width_q;
    trigger_done_d = 1'b0;
    echo_valid_d   = 1'b0;
    timeout_d      = 1'b0;

    if (clear_registers) begin
      state_d      = IDLE;
      cnt_d        = 16'd0;
      echo_width_d = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_trigger) begin
            state_d = TRIG;
            cnt_d   = 16'd0;
          end
        end

        TRIG: begin
          if (cnt_q == TRIG_LAST) begin
            state_d        = HOLDOFF;
            cnt_d          = 16'd0;
            trigger_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        HOLDOFF: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = WAIT_ECHO;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        WAIT_ECHO: begin
          if (echo_s && armed_q) begin
            // Count the rise cycle itself so the width matches echo_raw.
            state_d = ECHO_HIGH;
            cnt_d   = 16'd1;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = IDLE;
            cnt_d     = 16'd0;
            timeout_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + 16'd1;
            armed_d = armed_q | ~echo_s;
          end
        end

        ECHO_HIGH: begin
          if (!echo_s) begin
            state_d      = IDLE;
            cnt_d        = 16'd0;
            echo_width_d = cnt_q;
            echo_valid_d = 1'b1;
          end else if (cnt_q == 16'hFFFF) begin
            // Echo longer than the counter range: report saturated width
            // and flag it as a timeout in the same cycle.
            state_d      = IDLE;
            cnt_d        = 16'd0;
            echo_width_d = 16'hFFFF;
            echo_valid_d = 1'b1;
            timeout_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end
      endcase
    end

    // Level outputs are registered copies of the next state, so they line up
    // exactly with state_q and drop together with the strobes.
    trig_out_d   = (state_d == TRIG);
    echo_pulse_d = (state_d == ECHO_HIGH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= 16'd0;
      armed_q        <= 1'b0;
      echo_width_q   <= 16'd0;
      trig_out_q     <= 1'b0;
      trigger_done_q <= 1'b0;
      echo_pulse_q   <= 1'b0;
      echo_valid_q   <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      armed_q        <= armed_d;
      echo_width_q   <= echo_width_d;
      trig_out_q     <= trig_out_d;
      trigger_done_q <= trigger_done_d;
      echo_pulse_q   <= echo_pulse_d;
      echo_valid_q   <= echo_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  assign trig_out     = trig_out_q;
  assign trigger_done = trigger_done_q;
  assign echo_pulse   = echo_pulse_q;
  assign echo_width   = echo_width_q;
  assign echo_valid   = echo_valid_q;
  assign timeout      = timeout_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_sensor_frontend.sv
// -----------------------------------------------------------------------------
// tb_sensor_frontend
//
// Directed bench for sensor_frontend with TRIG_CYCLES=4, HOLDOFF_CYCLES=3,
// TIMEOUT_CYCLES=20. Expected echo_valid/timeout events ({valid, timeout,
// width}) are queued when the echo stimulus is driven and popped when the
// DUT raises either strobe. Define ECHO_GLITCH_FILTER_EN for both bench and
// design to exercise the filtered build.
// -----------------------------------------------------------------------------
module tb_sensor_frontend;

  localparam int          TRIG_C = 4;
  localparam int          HOLD_C = 3;
  localparam logic [15:0] TO_C   = 16'd20;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_trigger = 1'b0;
  logic        clear_registers = 1'b0;
  logic        echo_raw = 1'b0;
  logic        trig_out;
  logic        trigger_done;
  logic        echo_pulse;
  logic [15:0] echo_width;
  logic        echo_valid;
  logic        timeout;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  sensor_frontend #(
    .TRIG_CYCLES   (TRIG_C),
    .HOLDOFF_CYCLES(HOLD_C),
    .TIMEOUT_CYCLES(TO_C)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_trigger  (start_trigger),
    .clear_registers(clear_registers),
    .echo_raw       (echo_raw),
    .trig_out       (trig_out),
    .trigger_done   (trigger_done),
    .echo_pulse     (echo_pulse),
    .echo_width     (echo_width),
    .echo_valid     (echo_valid),
    .timeout        (timeout),
    .state_dbg      (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          failures = 0;
  logic [17:0] exp_q[$];
  logic [15:0] exp_width = 16'd0;

  // Running totals of output activity, sampled on the falling edge.
  int   trig_tot = 0, done_tot = 0, pulse_tot = 0, valid_tot = 0, to_tot = 0;
  int   long_tot = 0, align_bad = 0;
  logic prev_trig = 1'b0, prev_done = 1'b0, prev_valid = 1'b0, prev_to = 1'b0;
  int   snap_trig, snap_done, snap_pulse, snap_valid, snap_to;

  always @(negedge clk) begin
    trig_tot  <= trig_tot  + int'(trig_out);
    done_tot  <= done_tot  + int'(trigger_done);
    pulse_tot <= pulse_tot + int'(echo_pulse);
    valid_tot <= valid_tot + int'(echo_valid);
    to_tot    <= to_tot    + int'(timeout);
    if ((trigger_done && prev_done) || (echo_valid && prev_valid) || (timeout && prev_to))
      long_tot <= long_tot + 1;
    // trigger_done must coincide with the first low cycle of trig_out.
    if (trigger_done && !(prev_trig && !trig_out))
      align_bad <= align_bad + 1;
    prev_trig  <= trig_out;
    prev_done  <= trigger_done;
    prev_valid <= echo_valid;
    prev_to    <= timeout;
  end

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic snapshot();
    snap_trig  = trig_tot;
    snap_done  = done_tot;
    snap_pulse = pulse_tot;
    snap_valid = valid_tot;
    snap_to    = to_tot;
  endtask

  task automatic pop_compare(input string tag, input logic seen, input logic [17:0] got);
    logic [17:0] exp_v;
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_queued"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check(tag, 32'(got), 32'(exp_v));
    end
  endtask

  task automatic wait_result(input string tag, input int budget);
    logic        seen;
    logic [17:0] got;
    seen = 1'b0;
    got  = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (echo_valid || timeout) begin
        seen = 1'b1;
        got  = {echo_valid, timeout, echo_width};
        break;
      end
    end
    pop_compare(tag, seen, got);
  endtask

  // Caller is at a falling edge. Fires a trigger, drives an echo of w cycles
  // once the DUT is waiting, and checks the complete measurement.
  task automatic nominal(input string tag, input int w);
    snapshot();
    start_trigger = 1'b1;
    @(negedge clk);
    start_trigger = 1'b0;
    check({tag, "_trig_first_edge"}, 32'(trig_out), 32'd1);
    repeat (9) @(negedge clk);
    echo_raw = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 16'(w)});
    repeat (w) @(negedge clk);
    echo_raw = 1'b0;
    exp_width = 16'(w);
    wait_result({tag, "_result"}, 30);
    repeat (3) @(negedge clk);
    check({tag, "_trig_cycles"}, 32'(trig_tot - snap_trig), 32'(TRIG_C));
    check({tag, "_done_pulses"}, 32'(done_tot - snap_done), 32'd1);
    check({tag, "_pulse_cycles"}, 32'(pulse_tot - snap_pulse), 32'(w));
    check({tag, "_valid_pulses"}, 32'(valid_tot - snap_valid), 32'd1);
    check({tag, "_timeout_pulses"}, 32'(to_tot - snap_to), 32'd0);
    check({tag, "_width_hold"}, 32'(echo_width), 32'(exp_width));
    check({tag, "_state_idle"}, 32'(state_dbg), 32'(S_IDLE));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin : main_seq
    logic        seen;
    int          n;
    logic [17:0] got;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_trig_out", 32'(trig_out), 32'd0);
    check("rst_trigger_done", 32'(trigger_done), 32'd0);
    check("rst_echo_pulse", 32'(echo_pulse), 32'd0);
    check("rst_echo_width", 32'(echo_width), 32'd0);
    check("rst_echo_valid", 32'(echo_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal 50-cycle echo
    nominal("nom50", 50);

    // No echo: timeout 20 cycles after WAIT_ECHO entry, width unchanged
    snapshot();
    exp_q.push_back({1'b0, 1'b1, exp_width});
    start_trigger = 1'b1;
    @(negedge clk);
    start_trigger = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (state_dbg == S_WAIT) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("noecho_wait_entry", 32'(seen), 32'd1);
    n = 0;
    got = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (timeout || echo_valid) begin
        n   = i;
        got = {echo_valid, timeout, echo_width};
        break;
      end
    end
    check("noecho_latency", 32'(n), 32'(TO_C));
    pop_compare("noecho_result", n != 0, got);
    repeat (3) @(negedge clk);
    check("noecho_width_hold", 32'(echo_width), 32'(exp_width));
    check("noecho_state_idle", 32'(state_dbg), 32'(S_IDLE));
    check("noecho_no_pulse", 32'(pulse_tot - snap_pulse), 32'd0);

    // Echo already high through hold-off: needs a low, then a rise
    snapshot();
    start_trigger = 1'b1;
    @(negedge clk);
    start_trigger = 1'b0;
    echo_raw = 1'b1;
    repeat (12) @(negedge clk);
    check("holdoff_no_pulse", 32'(pulse_tot - snap_pulse), 32'd0);
    check("holdoff_still_waiting", 32'(state_dbg), 32'(S_WAIT));
    echo_raw = 1'b0;
    repeat (4) @(negedge clk);
    echo_raw = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 16'd7});
    repeat (7) @(negedge clk);
    echo_raw = 1'b0;
    exp_width = 16'd7;
    wait_result("holdoff_result", 30);
    repeat (3) @(negedge clk);
    check("holdoff_pulse_cycles", 32'(pulse_tot - snap_pulse), 32'd7);
    check("holdoff_width", 32'(echo_width), 32'(exp_width));

    // Reset low mid-TRIG: outputs drop without a clock edge
    snapshot();
    start_trigger = 1'b1;
    @(negedge clk);
    start_trigger = 1'b0;
    @(negedge clk);
    check("midtrig_trig_high", 32'(trig_out), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("midtrig_trig_out", 32'(trig_out), 32'd0);
    check("midtrig_trigger_done", 32'(trigger_done), 32'd0);
    check("midtrig_echo_pulse", 32'(echo_pulse), 32'd0);
    check("midtrig_echo_width", 32'(echo_width), 32'd0);
    check("midtrig_echo_valid", 32'(echo_valid), 32'd0);
    check("midtrig_timeout", 32'(timeout), 32'd0);
    check("midtrig_state", 32'(state_dbg), 32'(S_IDLE));
    exp_width = 16'd0;
    repeat (3) @(negedge clk);
    check("midtrig_no_done", 32'(done_tot - snap_done), 32'd0);
    // Release with start_trigger already high: honoured on the first edge.
    reset = 1'b1;
    nominal("rerun33", 33);

    // Abort with clear_registers in ECHO_HIGH
    snapshot();
    start_trigger = 1'b1;
    @(negedge clk);
    start_trigger = 1'b0;
    repeat (9) @(negedge clk);
    echo_raw = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (echo_pulse) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_echo_seen", 32'(seen), 32'd1);
    repeat (10) @(negedge clk);
    clear_registers = 1'b1;
    @(negedge clk);
    clear_registers = 1'b0;
    exp_width = 16'd0;
    check("abort_echo_pulse", 32'(echo_pulse), 32'd0);
    check("abort_echo_width", 32'(echo_width), 32'(exp_width));
    check("abort_state", 32'(state_dbg), 32'(S_IDLE));
    repeat (5) @(negedge clk);
    echo_raw = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_valid", 32'(valid_tot - snap_valid), 32'd0);
    check("abort_no_timeout", 32'(to_tot - snap_to), 32'd0);

    // clear_registers together with start_trigger in IDLE
    snapshot();
    clear_registers = 1'b1;
    start_trigger   = 1'b1;
    @(negedge clk);
    clear_registers = 1'b0;
    start_trigger   = 1'b0;
    check("clrstart_trig_out", 32'(trig_out), 32'd0);
    check("clrstart_state", 32'(state_dbg), 32'(S_IDLE));
    repeat (10) @(negedge clk);
    check("clrstart_no_trig", 32'(trig_tot - snap_trig), 32'd0);

`ifdef ECHO_GLITCH_FILTER_EN
    // 2-cycle glitch is rejected and the wait times out
    snapshot();
    exp_q.push_back({1'b0, 1'b1, exp_width});
    start_trigger = 1'b1;
    @(negedge clk);
    start_trigger = 1'b0;
    repeat (9) @(negedge clk);
    echo_raw = 1'b1;
    repeat (2) @(negedge clk);
    echo_raw = 1'b0;
    wait_result("glitch_result", 40);
    check("glitch_no_pulse", 32'(pulse_tot - snap_pulse), 32'd0);
    repeat (2) @(negedge clk);
    nominal("filt3", 3);
`else
    // Short echoes pass straight through the synchronizer
    nominal("short2", 2);
    nominal("short1", 1);
`endif

    repeat (3) @(negedge clk);
    check("strobe_single_cycle", 32'(long_tot), 32'd0);
    check("done_alignment", 32'(align_bad), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
